// File: rtl/cdb_if.sv
// CDB arbiter bus: ALU and load/store result inputs, plus the registered common data bus output.
// Handshake: a source transfer happens at a rising edge where valid & ready are both 1; ready never depends on valid.
interface cdb_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) ();
    logic              alu_valid;
    logic              alu_ready;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_value;
    logic [31:0]       alu_topc;
    logic              alu_topc_vld;

    logic              lsb_valid;
    logic              lsb_ready;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_value;

    logic              cdb_valid;
    logic              cdb_src;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [31:0]       cdb_topc;
    logic              cdb_topc_vld;

    modport slave (
        input  alu_valid, alu_tag, alu_value, alu_topc, alu_topc_vld,
        input  lsb_valid, lsb_tag, lsb_value,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_topc, cdb_topc_vld
    );

    modport master (
        output alu_valid, alu_tag, alu_value, alu_topc, alu_topc_vld,
        output lsb_valid, lsb_tag, lsb_value,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_topc, cdb_topc_vld
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Writeback scheduler: two small per-source result FIFOs drained round-robin onto one registered CDB.
// Debug outputs expose FIFO occupancy and the round-robin pointer.
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear,
    cdb_if.slave                   bus,
    output logic [$clog2(DEPTH):0] o_dbg_alu_count,
    output logic [$clog2(DEPTH):0] o_dbg_lsb_count,
    output logic                   o_dbg_last_grant
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ALU_W = TAG_W + DATA_W + 33;
    localparam int LSB_W = TAG_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ALU_W-1:0]  r_alu_mem [DEPTH];
    logic [LSB_W-1:0]  r_lsb_mem [DEPTH];
    logic [PTR_W-1:0]  r_alu_wptr, r_alu_rptr, r_lsb_wptr, r_lsb_rptr;
    logic [CNT_W-1:0]  r_alu_count, r_lsb_count;
    logic              r_last_grant;

    logic              r_cdb_valid, r_cdb_src, r_cdb_topc_vld;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_value;
    logic [31:0]       r_cdb_topc;

    logic              w_run, w_alu_ready, w_lsb_ready, w_alu_push, w_lsb_push;
    logic              w_alu_ne, w_lsb_ne, w_grant_alu, w_grant_lsb;
    logic [TAG_W-1:0]  w_alu_tag, w_lsb_tag;
    logic [DATA_W-1:0] w_alu_value, w_lsb_value;
    logic [31:0]       w_alu_topc;
    logic              w_alu_topc_vld;

    always_comb begin
        w_run       = rdy & ~clear;
        w_alu_ready = w_run & (r_alu_count < FULL);
        w_lsb_ready = w_run & (r_lsb_count < FULL);
        w_alu_push  = bus.alu_valid & w_alu_ready;
        w_lsb_push  = bus.lsb_valid & w_lsb_ready;
        w_alu_ne    = (r_alu_count != '0);
        w_lsb_ne    = (r_lsb_count != '0);
        // On a tie the source that did not win last time goes next.
        w_grant_alu = w_run & w_alu_ne & (~w_lsb_ne | r_last_grant);
        w_grant_lsb = w_run & w_lsb_ne & (~w_alu_ne | ~r_last_grant);
        {w_alu_tag, w_alu_value, w_alu_topc, w_alu_topc_vld} = r_alu_mem[r_alu_rptr];
        {w_lsb_tag, w_lsb_value} = r_lsb_mem[r_lsb_rptr];
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_alu_push)
            r_alu_mem[r_alu_wptr] <= {bus.alu_tag, bus.alu_value, bus.alu_topc, bus.alu_topc_vld};
        if (w_lsb_push)
            r_lsb_mem[r_lsb_wptr] <= {bus.lsb_tag, bus.lsb_value};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_wptr     <= '0;
            r_alu_rptr     <= '0;
            r_alu_count    <= '0;
            r_lsb_wptr     <= '0;
            r_lsb_rptr     <= '0;
            r_lsb_count    <= '0;
            r_last_grant   <= 1'b1;
            r_cdb_valid    <= 1'b0;
            r_cdb_src      <= 1'b0;
            r_cdb_tag      <= '0;
            r_cdb_value    <= '0;
            r_cdb_topc     <= '0;
            r_cdb_topc_vld <= 1'b0;
        end else if (rdy) begin
            if (clear) begin
                r_alu_wptr   <= '0;
                r_alu_rptr   <= '0;
                r_alu_count  <= '0;
                r_lsb_wptr   <= '0;
                r_lsb_rptr   <= '0;
                r_lsb_count  <= '0;
                r_last_grant <= 1'b1;
                r_cdb_valid  <= 1'b0;
            end else begin
                if (w_alu_push) r_alu_wptr <= r_alu_wptr + 1'b1;
                if (w_grant_alu) r_alu_rptr <= r_alu_rptr + 1'b1;
                case ({w_alu_push, w_grant_alu})
                    2'b10:   r_alu_count <= r_alu_count + 1'b1;
                    2'b01:   r_alu_count <= r_alu_count - 1'b1;
                    default: r_alu_count <= r_alu_count;
                endcase

                if (w_lsb_push) r_lsb_wptr <= r_lsb_wptr + 1'b1;
                if (w_grant_lsb) r_lsb_rptr <= r_lsb_rptr + 1'b1;
                case ({w_lsb_push, w_grant_lsb})
                    2'b10:   r_lsb_count <= r_lsb_count + 1'b1;
                    2'b01:   r_lsb_count <= r_lsb_count - 1'b1;
                    default: r_lsb_count <= r_lsb_count;
                endcase

                if (w_grant_alu) begin
                    r_cdb_valid    <= 1'b1;
                    r_cdb_src      <= 1'b0;
                    r_cdb_tag      <= w_alu_tag;
                    r_cdb_value    <= w_alu_value;
                    r_cdb_topc     <= w_alu_topc;
                    r_cdb_topc_vld <= w_alu_topc_vld;
                    r_last_grant   <= 1'b0;
                end else if (w_grant_lsb) begin
                    r_cdb_valid    <= 1'b1;
                    r_cdb_src      <= 1'b1;
                    r_cdb_tag      <= w_lsb_tag;
                    r_cdb_value    <= w_lsb_value;
                    r_cdb_topc     <= '0;
                    r_cdb_topc_vld <= 1'b0;
                    r_last_grant   <= 1'b1;
                end else begin
                    r_cdb_valid    <= 1'b0;
                end
            end
        end
    end

    assign bus.alu_ready     = w_alu_ready;
    assign bus.lsb_ready     = w_lsb_ready;
    assign bus.cdb_valid     = r_cdb_valid;
    assign bus.cdb_src       = r_cdb_src;
    assign bus.cdb_tag       = r_cdb_tag;
    assign bus.cdb_value     = r_cdb_value;
    assign bus.cdb_topc      = r_cdb_topc;
    assign bus.cdb_topc_vld  = r_cdb_topc_vld;
    assign o_dbg_alu_count   = r_alu_count;
    assign o_dbg_lsb_count   = r_lsb_count;
    assign o_dbg_last_grant  = r_last_grant;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected CDB results are queued when offered and checked as they appear.
module tb_cdb_arbiter;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int EW     = 1 + TAG_W + DATA_W + 33;

    logic clk, rst, rdy, clear;
    logic [$clog2(DEPTH):0] dbg_alu_count, dbg_lsb_count;
    logic dbg_last_grant;

    cdb_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .clear            (clear),
        .bus              (bus),
        .o_dbg_alu_count  (dbg_alu_count),
        .o_dbg_lsb_count  (dbg_lsb_count),
        .o_dbg_last_grant (dbg_last_grant)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    bit prev_live = 1'b0;
    int a_tags[$];
    int l_tags[$];

    function automatic logic [EW-1:0] alu_ent(input int tag, input logic [31:0] value,
                                              input logic [31:0] topc, input logic vld);
        return {1'b0, TAG_W'(tag), value, topc, vld};
    endfunction

    function automatic logic [EW-1:0] lsb_ent(input int tag, input logic [31:0] value);
        return {1'b1, TAG_W'(tag), value, 32'h0, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input int tag, input logic [31:0] value,
                           input logic [31:0] topc, input logic vld);
        bus.alu_valid    = v;
        bus.alu_tag      = TAG_W'(tag);
        bus.alu_value    = value;
        bus.alu_topc     = topc;
        bus.alu_topc_vld = vld;
    endtask

    task automatic set_lsb(input logic v, input int tag, input logic [31:0] value);
        bus.lsb_valid = v;
        bus.lsb_tag   = TAG_W'(tag);
        bus.lsb_value = value;
    endtask

    function automatic logic [31:0] aval(input int t);  return 32'hA000_0000 + t; endfunction
    function automatic logic [31:0] atopc(input int t); return 32'h0000_1000 + 4 * t; endfunction
    function automatic logic [31:0] lval(input int t);  return 32'hB000_0000 + t; endfunction

    // One-cycle flush; leaves both FIFOs empty and the tie going to the ALU.
    task automatic do_clear(input string tag);
        clear = 1'b1;
        @(negedge clk);
        check({tag, "_ready_during_clear"}, {bus.alu_ready, bus.lsb_ready}, 2'b00);
        tick();
        clear = 1'b0;
        @(negedge clk);
        check({tag, "_after_clear"}, {bus.cdb_valid, dbg_alu_count, dbg_lsb_count, dbg_last_grant},
              {1'b0, 2'd0, 2'd0, 1'b1});
        tick();
    endtask

    // Offer a_tags / l_tags concurrently, each source holding its offer until accepted.
    task automatic contend(input string tag, input bit check_full);
        int ai = 0;
        int li = 0;
        int cyc = 0;
        bit saw_full = 1'b0;
        bit a_acc, l_acc;
        while ((ai < a_tags.size() || li < l_tags.size()) && cyc < 50) begin
            if (ai < a_tags.size()) set_alu(1'b1, a_tags[ai], aval(a_tags[ai]), atopc(a_tags[ai]), a_tags[ai][0]);
            else                    set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
            if (li < l_tags.size()) set_lsb(1'b1, l_tags[li], lval(l_tags[li]));
            else                    set_lsb(1'b0, 0, 32'h0);
            @(negedge clk);
            a_acc = bus.alu_valid & bus.alu_ready;
            l_acc = bus.lsb_valid & bus.lsb_ready;
            if (check_full && dbg_alu_count == 2) begin
                saw_full = 1'b1;
                check({tag, "_alu_ready_when_full"}, bus.alu_ready, 1'b0);
            end
            tick();
            if (a_acc) ai++;
            if (l_acc) li++;
            cyc++;
        end
        set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
        set_lsb(1'b0, 0, 32'h0);
        check({tag, "_offers_accepted"}, (cyc < 50), 1'b1);
        if (check_full) check({tag, "_alu_fifo_reached_full"}, saw_full, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // scoreboard: a new CDB result is one that appears after an active, unfrozen edge
    always @(posedge clk) prev_live = rst && rdy;

    always @(negedge clk) begin
        logic [EW-1:0] obs;
        logic [EW-1:0] exp;
        if (prev_live && bus.cdb_valid === 1'b1) begin
            obs = {bus.cdb_src, bus.cdb_tag, bus.cdb_value, bus.cdb_topc, bus.cdb_topc_vld};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL cdb_unexpected: observed %0h expected no result", obs);
            end else begin
                exp = exp_q.pop_front();
                check("cdb_result", obs, exp);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
        set_lsb(1'b0, 0, 32'h0);

        // reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.cdb_valid, bus.cdb_src, bus.cdb_tag, bus.cdb_value, bus.cdb_topc, bus.cdb_topc_vld},
              '0);
        check("reset_ready", {bus.alu_ready, bus.lsb_ready, dbg_last_grant}, 3'b111);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_no_cdb", bus.cdb_valid, 1'b0);
            tick();
        end

        // single ALU result: on the CDB after the second edge only
        set_alu(1'b1, 3, 32'h1, 32'h100, 1'b1);
        exp_q.push_back(alu_ent(3, 32'h1, 32'h100, 1'b1));
        tick();
        set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("single_no_bypass", {bus.cdb_valid, dbg_alu_count}, {1'b0, 2'd1});
        tick();
        tick();
        @(negedge clk);
        check("single_pulse_ends", bus.cdb_valid, 1'b0);
        drain("single");

        // tie and round-robin
        do_clear("tie");
        a_tags = '{1, 2};
        l_tags = '{5, 6};
        exp_q.push_back(alu_ent(1, aval(1), atopc(1), 1'b1));
        exp_q.push_back(lsb_ent(5, lval(5)));
        exp_q.push_back(alu_ent(2, aval(2), atopc(2), 1'b0));
        exp_q.push_back(lsb_ent(6, lval(6)));
        contend("tie", 1'b0);
        drain("tie");

        // full ALU FIFO under contention; order across pointer wrap
        do_clear("full");
        a_tags = '{7, 8, 9, 13};
        l_tags = '{10, 11, 12};
        exp_q.push_back(alu_ent(7, aval(7), atopc(7), 1'b1));
        exp_q.push_back(lsb_ent(10, lval(10)));
        exp_q.push_back(alu_ent(8, aval(8), atopc(8), 1'b0));
        exp_q.push_back(lsb_ent(11, lval(11)));
        exp_q.push_back(alu_ent(9, aval(9), atopc(9), 1'b1));
        exp_q.push_back(lsb_ent(12, lval(12)));
        exp_q.push_back(alu_ent(13, aval(13), atopc(13), 1'b1));
        contend("full", 1'b1);
        drain("full");

        // flush: one result on the CDB, two LSB entries buffered
        do_clear("flush_setup");
        set_alu(1'b1, 14, aval(14), atopc(14), 1'b0);
        set_lsb(1'b1, 12, lval(12));
        exp_q.push_back(alu_ent(14, aval(14), atopc(14), 1'b0));
        tick();
        set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
        set_lsb(1'b1, 13, lval(13));
        tick();
        set_lsb(1'b0, 0, 32'h0);
        set_alu(1'b1, 9, 32'hDEAD, 32'h0, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        check("flush_before", {bus.cdb_valid, dbg_lsb_count, bus.alu_ready}, {1'b1, 2'd2, 1'b0});
        tick();
        clear = 1'b0;
        set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("flush_after", {bus.cdb_valid, dbg_alu_count, dbg_lsb_count}, {1'b0, 2'd0, 2'd0});
        tick();
        set_alu(1'b1, 15, aval(15), atopc(15), 1'b1);
        exp_q.push_back(alu_ent(15, aval(15), atopc(15), 1'b1));
        tick();
        set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
        drain("flush");

        // stall with a pending pulse and buffered entries
        do_clear("stall_setup");
        exp_q.push_back(alu_ent(1, aval(1), atopc(1), 1'b1));
        exp_q.push_back(lsb_ent(5, lval(5)));
        exp_q.push_back(alu_ent(2, aval(2), atopc(2), 1'b0));
        exp_q.push_back(lsb_ent(6, lval(6)));
        set_alu(1'b1, 1, aval(1), atopc(1), 1'b1);
        set_lsb(1'b1, 5, lval(5));
        tick();
        set_alu(1'b1, 2, aval(2), atopc(2), 1'b0);
        set_lsb(1'b1, 6, lval(6));
        tick();
        set_lsb(1'b0, 0, 32'h0);
        set_alu(1'b1, 0, 32'hDEAD, 32'h0, 1'b0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("stall_frozen",
                  {bus.cdb_valid, bus.cdb_src, bus.cdb_tag, dbg_alu_count, dbg_lsb_count, bus.alu_ready, bus.lsb_ready},
                  {1'b1, 1'b0, 4'd1, 2'd1, 2'd2, 1'b0, 1'b0});
        end
        rdy = 1'b1;
        set_alu(1'b0, 0, 32'h0, 32'h0, 1'b0);
        drain("stall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
